// File: rtl/gf64_horner_eval.sv
// Streaming Horner-rule polynomial evaluator over GF(2^6) (x^6+x+1).
// One coefficient per cycle, highest degree first; result held until taken.
module gf64_horner_eval #(
  parameter int unsigned MAX_LEN = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [5:0] s_coef,
  input  logic [5:0] s_point,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [5:0] m_result,
  output logic [5:0] m_count,
  output logic       m_overflow
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [5:0] MAX_CNT = 6'(MAX_LEN);

  // Shift-and-add multiply, MSB of b first, reducing x^6 -> x+1 each step.
  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] p;
    p = '0;
    for (int i = 5; i >= 0; i--) begin
      p = {p[4:0], 1'b0} ^ (p[5] ? 6'h03 : 6'h00);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  logic [0:0] state_q;
  logic [5:0] acc_q, pt_q, cnt_q;
  logic       first_q, ovf_q;
  logic [5:0] res_q, res_cnt_q;
  logic       res_ovf_q;

  logic       beat;
  logic       at_max;
  logic [5:0] pt_use, acc_nxt, cnt_nxt;
  logic       ovf_nxt;

  always_comb begin
    beat    = s_valid & (state_q == ST_ACC);
    at_max  = (cnt_q == MAX_CNT);
    pt_use  = first_q ? s_point : pt_q;
    acc_nxt = gf_mul(acc_q, pt_use) ^ s_coef;
    cnt_nxt = at_max ? cnt_q : cnt_q + 6'd1;
    ovf_nxt = ovf_q | at_max;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      pt_q      <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (beat) begin
            acc_q   <= acc_nxt;
            pt_q    <= pt_use;
            cnt_q   <= cnt_nxt;
            ovf_q   <= ovf_nxt;
            first_q <= 1'b0;
            if (s_last) begin
              res_q     <= acc_nxt;
              res_cnt_q <= cnt_nxt;
              res_ovf_q <= ovf_nxt;
              state_q   <= ST_HOLD;
            end
          end
        end
        default: begin
          if (m_ready) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    s_ready    = (state_q == ST_ACC);
    m_valid    = (state_q == ST_HOLD);
    m_result   = res_q;
    m_count    = res_cnt_q;
    m_overflow = res_ovf_q;
  end

endmodule

// File: tb/tb_gf64_horner_eval.sv
// Bench for gf64_horner_eval: two instances (MAX_LEN 63 and 4) share one stimulus
// stream and are checked every cycle against a power-sum polynomial model.
module tb_gf64_horner_eval;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [5:0] s_coef = '0;
  logic [5:0] s_point = '0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b1;

  logic       s_ready, m_valid, m_overflow;
  logic [5:0] m_result, m_count;
  logic       s_ready4, m_valid4, m_overflow4;
  logic [5:0] m_result4, m_count4;

  gf64_horner_eval #(.MAX_LEN(63)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_coef(s_coef),
    .s_point(s_point), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_result(m_result), .m_count(m_count), .m_overflow(m_overflow)
  );

  gf64_horner_eval #(.MAX_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready4), .s_coef(s_coef),
    .s_point(s_point), .s_last(s_last), .m_valid(m_valid4), .m_ready(m_ready),
    .m_result(m_result4), .m_count(m_count4), .m_overflow(m_overflow4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: full carry-less product, then reduce by 0x43.
  function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
    logic [10:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) if (b[i]) p = p ^ (11'(a) << i);
    for (int k = 10; k >= 6; k--) if (p[k]) p = p ^ (11'h43 << (k - 6));
    return p[5:0];
  endfunction

  function automatic logic [5:0] ref_pow(input logic [5:0] x, input int e);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < e; i++) r = ref_mul(r, x);
    return r;
  endfunction

  function automatic logic [5:0] ref_eval(input logic [5:0] x, input logic [5:0] q[$]);
    logic [5:0] s;
    int n;
    s = '0;
    n = q.size();
    for (int i = 0; i < n; i++) s = s ^ ref_mul(q[i], ref_pow(x, n - 1 - i));
    return s;
  endfunction

  // Behavioural model: collect the frame, evaluate it once s_last is taken.
  logic [5:0] frame[$];
  logic [5:0] mdl_pt;
  bit         hold = 0;
  bit         started = 0;
  logic [5:0] e_res = '0, e_cnt = '0, e_cnt4 = '0;
  bit         e_ovf = 0, e_ovf4 = 0;

  initial forever begin
    int n;
    @(posedge clk);
    if (rst) begin
      hold = 0;
      frame.delete();
      e_res = '0; e_cnt = '0; e_cnt4 = '0; e_ovf = 0; e_ovf4 = 0;
      started = 1;
    end else if (hold) begin
      if (m_ready) hold = 0;
    end else if (s_valid) begin
      if (frame.size() == 0) mdl_pt = s_point;
      frame.push_back(s_coef);
      if (s_last) begin
        n      = frame.size();
        e_res  = ref_eval(mdl_pt, frame);
        e_cnt  = 6'((n > 63) ? 63 : n);
        e_ovf  = (n > 63);
        e_cnt4 = 6'((n > 4) ? 4 : n);
        e_ovf4 = (n > 4);
        hold   = 1;
        frame.delete();
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("s_ready", int'(s_ready), int'(!hold));
      chk("m_valid", int'(m_valid), int'(hold));
      chk("s_ready4", int'(s_ready4), int'(!hold));
      chk("m_valid4", int'(m_valid4), int'(hold));
      if (hold) begin
        chk("m_result", int'(m_result), int'(e_res));
        chk("m_count", int'(m_count), int'(e_cnt));
        chk("m_overflow", int'(m_overflow), int'(e_ovf));
        chk("m_result4", int'(m_result4), int'(e_res));
        chk("m_count4", int'(m_count4), int'(e_cnt4));
        chk("m_overflow4", int'(m_overflow4), int'(e_ovf4));
      end
    end
  end

  // m_ready: 0 = always high, 1 = random, 2 = held low
  int mr_mode = 0;
  initial forever begin
    @(negedge clk);
    case (mr_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  task automatic beat(input logic [5:0] c, input logic [5:0] p, input logic l);
    int w;
    w = 0;
    s_valid = 1'b1; s_coef = c; s_point = p; s_last = l;
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("beat_timeout", 0, 1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  logic [5:0] dir_q[$];

  task automatic send_q(input logic [5:0] pt, input bit gaps);
    for (int i = 0; i < dir_q.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      beat(dir_q[i], (i == 0) ? pt : 6'($urandom), i == dir_q.size() - 1);
    end
  endtask

  logic [5:0] r_res, r_cnt, r_cnt4;
  logic       r_ovf, r_ovf4;

  task automatic wait_result();
    int w;
    w = 0;
    while (!m_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("result_timeout", 0, 1);
    r_res = m_result; r_cnt = m_count; r_ovf = m_overflow;
    r_cnt4 = m_count4; r_ovf4 = m_overflow4;
    w = 0;
    while (m_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_result", int'(m_result), 0);
    chk("rst_m_count", int'(m_count), 0);
    chk("rst_m_overflow", int'(m_overflow), 0);

    // model pins
    chk("ref_x6", int'(ref_mul(6'h20, 6'h02)), 'h03);
    chk("ref_pow", int'(ref_pow(6'h02, 6)), 'h03);

    dir_q = '{6'h2A};
    beat(6'h2A, 6'h07, 1'b1);
    chk("t1_latency_valid", int'(m_valid), 1);
    wait_result();
    chk("t1_result", int'(r_res), 'h2A);
    chk("t1_count", int'(r_cnt), 1);
    chk("t1_ovf", int'(r_ovf), 0);

    dir_q = '{6'h01, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    send_q(6'h02, 0);
    wait_result();
    chk("t2_result", int'(r_res), 'h03);
    chk("t2_count", int'(r_cnt), 7);
    chk("t2_count4", int'(r_cnt4), 4);
    chk("t2_ovf4", int'(r_ovf4), 1);

    dir_q = '{6'h3F, 6'h15, 6'h2A};
    send_q(6'h01, 0);
    wait_result();
    chk("t3a_result", int'(r_res), 'h00);
    dir_q = '{6'h05, 6'h09, 6'h11};
    send_q(6'h00, 0);
    wait_result();
    chk("t3b_result", int'(r_res), 'h11);

    // Bubbles and changing s_point after the first beat
    dir_q = '{6'h01, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    send_q(6'h02, 1);
    wait_result();
    chk("t5_result", int'(r_res), 'h03);

    dir_q = '{6'h01, 6'h01, 6'h01, 6'h01, 6'h01};
    send_q(6'h01, 0);
    wait_result();
    chk("t6_result4", int'(r_res), 'h01);
    chk("t6_count4", int'(r_cnt4), 4);
    chk("t6_ovf4", int'(r_ovf4), 1);
    chk("t6_count63", int'(r_cnt), 5);
    chk("t6_ovf63", int'(r_ovf), 0);

    // Backpressure: 0x11*3 ^ 0x22 = 0x11
    mr_mode = 2;
    repeat (2) @(negedge clk);
    dir_q = '{6'h11, 6'h22};
    send_q(6'h03, 0);
    s_valid = 1'b1; s_coef = 6'h3F; s_last = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t4_s_ready", int'(s_ready), 0);
      chk("t4_m_valid", int'(m_valid), 1);
      chk("t4_result", int'(m_result), 'h11);
      chk("t4_count", int'(m_count), 2);
    end
    s_valid = 1'b0; s_last = 1'b0;
    mr_mode = 0;
    n = 0;
    while (m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t4_release", int'(s_ready), 1);

    // Reset mid-frame discards the partial frame
    beat(6'h2A, 6'h05, 1'b0);
    beat(6'h33, 6'h05, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    beat(6'h15, 6'h09, 1'b1);
    wait_result();
    chk("t7_result", int'(r_res), 'h15);
    chk("t7_count", int'(r_cnt), 1);

    // Random frames, random backpressure, bubbles; some frames exceed 63 beats
    mr_mode = 1;
    for (int f = 0; f < 40; f++) begin
      logic [5:0] pt;
      n  = (f % 5 == 0) ? $urandom_range(60, 70) : $urandom_range(1, 12);
      pt = 6'($urandom);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        beat(6'($urandom), (i == 0) ? pt : 6'($urandom), i == n - 1);
      end
    end
    mr_mode = 0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
